ad9226_frame_packer: RTL and testbench
======================================

Name: ad9226_frame_packer

Overview:
- Multi-channel successor to the single-channel AD9226 sample packer.
- Captures CHANNELS parallel ADC words per sys_clk, optionally decimates them, and packs SAMPLES captures into one wide FIFO word.
- Drops whole frames when the downstream FIFO is full and counts them.
- Sits between the AD9226 input registers and the W5500-side packet FIFO.

Parameters:
- ADC_BITS, 12, bits per ADC sample
- CHANNELS, 2, number of ADC channels sampled in parallel
- SAMPLES, 20, captures per frame (per channel); must be >= 2
- DECIM_W, 8, width of the decimation ratio input
- CNT_W, 16, width of the frame and drop counters

Ports:
- sys_clk  in  1  system/ADC clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable; low discards any partial frame
- decim  in  DECIM_W  keep 1 of (decim+1) input samples
- clear_stat  in  1  synchronous clear of counters and the sticky flag
- fifo_full  in  1  downstream FIFO full
- data_in  in  CHANNELS*ADC_BITS  channel c in bits [c*ADC_BITS +: ADC_BITS]
- fifo_write_enable  out  1  one-cycle FIFO write strobe
- data_out  out  CHANNELS*ADC_BITS*SAMPLES  packed frame
- frame_cnt  out  CNT_W  frames written to FIFO
- drop_cnt  out  CNT_W  frames dropped because of fifo_full
- overflow  out  1  sticky: at least one frame dropped

Behaviour:
- Clock and reset:
  - Single clock sys_clk; reset_n is asynchronous, active-low.
  - All outputs are registered. Reset values: fifo_write_enable=0, data_out=0, frame_cnt=0, drop_cnt=0, overflow=0, state=IDLE, sample index=0, decimation counter=0.
- States: IDLE and FILL.
  - IDLE -> FILL on the first edge where enable=1.
  - FILL -> IDLE on any edge where enable=0. The partial frame is discarded, the index resets to 0, and nothing is written.
- Decimation:
  - The decimation counter is reloaded with the current decim value on the edge a sample is kept. Otherwise it decrements.
  - A sample is kept when the counter is 0 in FILL.
  - decim=0 keeps every cycle. The first cycle in FILL is always kept.
  - A decim change takes effect at the next reload.
- Packing:
  - The kept capture at index k (0..SAMPLES-1) is written to shadow bits [k*CHANNELS*ADC_BITS +: CHANNELS*ADC_BITS]. Capture 0 goes in the LSBs, with channel order preserved inside each slot.
- Frame completion (edge where capture SAMPLES-1 is kept), with fifo_full sampled on the same edge:
  - fifo_full=0: on the next cycle, data_out = completed shadow frame, fifo_write_enable=1 for exactly one cycle, and frame_cnt increments.
  - fifo_full=1: data_out is unchanged, no strobe is issued, drop_cnt increments, and overflow is set.
  - Index wraps to 0 and capture continues with no gap. The ADC stream is never back-pressured.
- data_out holds its value between strobes.
- Counters saturate at all-ones and do not wrap.
- clear_stat zeroes frame_cnt, drop_cnt and overflow. If it coincides with a frame completion, the clear wins for that edge and the completion's increment is lost; the write itself still occurs.
- Latency: fifo_write_enable is asserted 1 cycle after the edge on which the last sample of the frame is captured.
- Reset asserted mid-frame: everything returns to reset values immediately; no strobe is issued.

Optional Feature:
- Macro: AD9226_TESTPAT_EN.
- When defined, the packer has an extra input port testpat (1 bit).
- While testpat=1, each kept capture replaces data_in channel c with (ramp + c) mod 2^ADC_BITS. ramp is an ADC_BITS counter that is reset to 0 and increments on every kept capture.
- When the macro is undefined, there is no port and no ramp logic, and data_in is always used.

Test Plan:
- Packing, CHANNELS=1, ADC_BITS=12, SAMPLES=4, decim=0, enable=1: data_in = 0xF0F, 0x909, 0x707, 0xE0E on successive cycles -> one strobe 1 cycle after the 4th capture with data_out=0xE0E_707_909_F0F and frame_cnt=1.
- CHANNELS=2, SAMPLES=2: data_in = {ch1,ch0} = {0x111,0x222} then {0x333,0x444} -> data_out=0x333444_111222.
- Decimation: decim=2 with a ramp 0,1,2,... on data_in, CHANNELS=1, SAMPLES=4 -> data_out holds 9,6,3,0 (MSB to LSB), with the strobe 10 cycles after FILL entry.
- Overflow: fifo_full=1 at the completion edge of frame 2 -> no strobe, drop_cnt=1, overflow=1, data_out still frame 1. Frame 3 with fifo_full=0 is written normally. A clear_stat pulse then zeroes both counters and overflow.
- Abort: enable drops after 2 of 4 captures, then rises again -> no strobe; the next frame starts at index 0 and contains only post-restart samples.
- Reset mid-frame, plus saturation: reset_n low for 3 cycles during FILL -> all outputs 0. With CNT_W=2, 5 dropped frames -> drop_cnt=3.

Source files
------------

// File: rtl/ad9226_frame_packer.sv
// Multi-channel AD9226 frame packer: captures CHANNELS words per kept cycle, decimates, and packs
// SAMPLES captures per FIFO word. Optional test-pattern ramp input is enabled by AD9226_TESTPAT_EN.
module ad9226_frame_packer #(
  parameter int unsigned ADC_BITS = 12,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SAMPLES  = 20,
  parameter int unsigned DECIM_W  = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                                   sys_clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic [DECIM_W-1:0]                     decim,
  input  logic                                   clear_stat,
  input  logic                                   fifo_full,
`ifdef AD9226_TESTPAT_EN
  input  logic                                   testpat,
`endif
  input  logic [CHANNELS*ADC_BITS-1:0]           data_in,
  output logic                                   fifo_write_enable,
  output logic [CHANNELS*ADC_BITS*SAMPLES-1:0]   data_out,
  output logic [CNT_W-1:0]                       frame_cnt,
  output logic [CNT_W-1:0]                       drop_cnt,
  output logic                                   overflow
);

  localparam int unsigned SLOT_W  = CHANNELS * ADC_BITS;
  localparam int unsigned FRAME_W = SLOT_W * SAMPLES;
  localparam int unsigned IDX_W   = $clog2(SAMPLES);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DECIM_W-1:0]   skip_q, skip_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic [FRAME_W-1:0]   dout_q, dout_d;
  logic                 we_q, we_d;
  logic [CNT_W-1:0]     frames_q, frames_d;
  logic [CNT_W-1:0]     drops_q, drops_d;
  logic                 ovf_q, ovf_d;

  logic                 keep;
  logic                 last;
  logic [SLOT_W-1:0]    capture;
  logic [FRAME_W-1:0]   frame_next;

  assign keep = (state_q == StFill) && enable && (skip_q == '0);
  assign last = keep && (idx_q == IDX_W'(SAMPLES - 1));

`ifdef AD9226_TESTPAT_EN
  logic [ADC_BITS-1:0] ramp_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_q <= '0;
    end else if (keep) begin
      ramp_q <= ramp_q + 1'b1;
    end
  end

  always_comb begin
    capture = data_in;
    if (testpat) begin
      for (int c = 0; c < CHANNELS; c++) begin
        capture[c*ADC_BITS +: ADC_BITS] = ramp_q + ADC_BITS'(c);
      end
    end
  end
`else
  assign capture = data_in;
`endif

  // The completing frame includes the capture taken on this very edge.
  always_comb begin
    frame_next = shadow_q;
    frame_next[int'(idx_q)*SLOT_W +: SLOT_W] = capture;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    skip_d   = skip_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    we_d     = 1'b0;
    frames_d = frames_q;
    drops_d  = drops_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle: begin
        if (enable) state_d = StFill;
      end
      StFill: begin
        if (!enable) begin
          state_d = StIdle;
          idx_d   = '0;
          skip_d  = '0;
        end else if (skip_q == '0) begin
          skip_d   = decim;
          shadow_d = frame_next;
          idx_d    = last ? '0 : idx_q + 1'b1;
        end else begin
          skip_d = skip_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (last) begin
      if (!fifo_full) begin
        dout_d = frame_next;
        we_d   = 1'b1;
        if (frames_q != '1) frames_d = frames_q + 1'b1;
      end else begin
        if (drops_q != '1) drops_d = drops_q + 1'b1;
        ovf_d = 1'b1;
      end
    end

    // Clear beats a coincident completion; the write itself is unaffected.
    if (clear_stat) begin
      frames_d = '0;
      drops_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      skip_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      we_q     <= 1'b0;
      frames_q <= '0;
      drops_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      skip_q   <= skip_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      we_q     <= we_d;
      frames_q <= frames_d;
      drops_q  <= drops_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fifo_write_enable = we_q;
  assign data_out          = dout_q;
  assign frame_cnt         = frames_q;
  assign drop_cnt          = drops_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_ad9226_frame_packer.sv
// Scoreboard bench for ad9226_frame_packer: directed scenarios plus random traffic against a
// capture-list reference model; a monitor compares every cycle and pops frames on each strobe.
module tb_ad9226_frame_packer;

  localparam int unsigned ADC_BITS = 12;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned SAMPLES  = 4;
  localparam int unsigned DECIM_W  = 8;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned SLOT_W   = CHANNELS * ADC_BITS;
  localparam int unsigned FRAME_W  = SLOT_W * SAMPLES;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic                sys_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                enable = 1'b0;
  logic [DECIM_W-1:0]  decim = '0;
  logic                clear_stat = 1'b0;
  logic                fifo_full = 1'b0;
  logic [SLOT_W-1:0]   data_in = '0;
  logic                fifo_write_enable;
  logic [FRAME_W-1:0]  data_out;
  logic [CNT_W-1:0]    frame_cnt;
  logic [CNT_W-1:0]    drop_cnt;
  logic                overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: captures collected so far in the current frame.
  bit                  m_fill = 0;
  int                  m_skip = 0;
  logic [SLOT_W-1:0]   m_caps[$];
  logic [FRAME_W-1:0]  m_dout = '0;
  bit                  m_strobe = 0;
  int                  m_frames = 0;
  int                  m_drops = 0;
  bit                  m_ovf = 0;
  logic [FRAME_W-1:0]  exp_q[$];

  ad9226_frame_packer #(
    .ADC_BITS (ADC_BITS),
    .CHANNELS (CHANNELS),
    .SAMPLES  (SAMPLES),
    .DECIM_W  (DECIM_W),
    .CNT_W    (CNT_W)
  ) dut (
    .sys_clk           (sys_clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .decim             (decim),
    .clear_stat        (clear_stat),
    .fifo_full         (fifo_full),
`ifdef AD9226_TESTPAT_EN
    .testpat           (1'b0),
`endif
    .data_in           (data_in),
    .fifo_write_enable (fifo_write_enable),
    .data_out          (data_out),
    .frame_cnt         (frame_cnt),
    .drop_cnt          (drop_cnt),
    .overflow          (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [FRAME_W-1:0] act,
                       input logic [FRAME_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  function automatic void model_reset();
    m_fill = 0;
    m_skip = 0;
    m_caps.delete();
    m_dout = '0;
    m_strobe = 0;
    m_frames = 0;
    m_drops = 0;
    m_ovf = 0;
    exp_q.delete();
  endfunction

  // Effect of one clock edge with the given inputs.
  function automatic void model_step(bit en, int dec, bit clr, bit full,
                                     logic [SLOT_W-1:0] din);
    bit done = 0;
    logic [FRAME_W-1:0] f = '0;
    m_strobe = 0;
    if (!m_fill) begin
      if (en) m_fill = 1;
    end else if (!en) begin
      m_fill = 0;
      m_skip = 0;
      m_caps.delete();
    end else if (m_skip > 0) begin
      m_skip--;
    end else begin
      m_caps.push_back(din);
      m_skip = dec;
      if (m_caps.size() == SAMPLES) begin
        for (int k = 0; k < SAMPLES; k++) f |= FRAME_W'(m_caps[k]) << (k * SLOT_W);
        m_caps.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!full) begin
        m_dout = f;
        m_strobe = 1;
        exp_q.push_back(f);
        m_frames = sat_inc(m_frames);
      end else begin
        m_drops = sat_inc(m_drops);
        m_ovf = 1;
      end
    end
    if (clr) begin
      m_frames = 0;
      m_drops = 0;
      m_ovf = 0;
    end
  endfunction

  task automatic step(input bit en, input int dec, input bit clr, input bit full,
                      input logic [SLOT_W-1:0] din);
    @(negedge sys_clk);
    enable = en;
    decim = DECIM_W'(dec);
    clear_stat = clr;
    fifo_full = full;
    data_in = din;
    model_step(en, dec, clr, full, din);
    @(posedge sys_clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge sys_clk);
    reset_n = 1'b0;
    enable = 1'b0;
    clear_stat = 1'b0;
    fifo_full = 1'b0;
    model_reset();
    #1;
    check("reset_strobe", FRAME_W'(fifo_write_enable), '0);
    check("reset_data_out", data_out, '0);
    check("reset_frame_cnt", FRAME_W'(frame_cnt), '0);
    check("reset_drop_cnt", FRAME_W'(drop_cnt), '0);
    check("reset_overflow", FRAME_W'(overflow), '0);
    repeat (cycles) @(negedge sys_clk);
    reset_n = 1'b1;
  endtask

  // Monitor: runs just after every active edge.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      check("strobe", FRAME_W'(fifo_write_enable), FRAME_W'(m_strobe));
      if (fifo_write_enable) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_write: got data %0h, expected no write", data_out);
        end else begin
          check("frame_data", data_out, exp_q.pop_front());
        end
      end
      check("data_out_hold", data_out, m_dout);
      check("frame_cnt", FRAME_W'(frame_cnt), FRAME_W'(m_frames));
      check("drop_cnt", FRAME_W'(drop_cnt), FRAME_W'(m_drops));
      check("overflow", FRAME_W'(overflow), FRAME_W'(m_ovf));
    end
  end

  initial begin
    do_reset(3);

    // Decimation by 3 on a ramp: keeps 0,3,6,9, strobe 10 edges after FILL entry.
    step(1, 2, 0, 0, '0);
    for (int j = 0; j < 10; j++) step(1, 2, 0, 0, {12'(j + 256), 12'(j)});
    #1;
    check("decim_strobe", FRAME_W'(fifo_write_enable), FRAME_W'(1));
    check("decim_frame", data_out, 96'h109009_106006_103003_100000);
    check("decim_frame_cnt", FRAME_W'(frame_cnt), FRAME_W'(1));
    step(0, 0, 0, 0, '0);

    // Overflow: frame 2 completes while full, frame 3 written, then clear.
    step(1, 0, 0, 0, '0);
    for (int j = 0; j < 4; j++) step(1, 0, 0, 0, SLOT_W'($urandom()));
    for (int j = 0; j < 4; j++) step(1, 0, 0, (j == 3), SLOT_W'($urandom()));
    #1;
    check("ovf_drop_cnt", FRAME_W'(drop_cnt), FRAME_W'(1));
    check("ovf_flag", FRAME_W'(overflow), FRAME_W'(1));
    check("ovf_no_strobe", FRAME_W'(fifo_write_enable), '0);
    for (int j = 0; j < 4; j++) step(1, 0, 0, 0, SLOT_W'($urandom()));
    step(0, 0, 1, 0, '0);
    #1;
    check("clear_frame_cnt", FRAME_W'(frame_cnt), '0);
    check("clear_drop_cnt", FRAME_W'(drop_cnt), '0);
    check("clear_overflow", FRAME_W'(overflow), '0);

    // Abort after 2 captures, restart and fill a fresh frame.
    step(1, 0, 0, 0, '0);
    for (int j = 0; j < 2; j++) step(1, 0, 0, 0, SLOT_W'($urandom()));
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    for (int j = 0; j < 5; j++) step(1, 0, 0, 0, SLOT_W'($urandom()));
    step(0, 0, 0, 0, '0);

    // Reset in the middle of a frame.
    step(1, 0, 0, 0, '0);
    for (int j = 0; j < 2; j++) step(1, 0, 0, 0, SLOT_W'($urandom()));
    do_reset(3);

    // Five dropped frames saturate the 2-bit drop counter.
    step(1, 0, 0, 1, '0);
    for (int j = 0; j < 20; j++) step(1, 0, 0, 1, SLOT_W'($urandom()));
    #1;
    check("sat_drop_cnt", FRAME_W'(drop_cnt), FRAME_W'(3));
    check("sat_overflow", FRAME_W'(overflow), FRAME_W'(1));
    step(0, 0, 1, 0, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 96, $urandom_range(0, 3), $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 25, SLOT_W'($urandom()));
    end

    repeat (3) step(0, 0, 0, 0, '0);
    check("queue_drained", FRAME_W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
